// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared types and constants for the instruction-fetch responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_MISS   = 2'd2,
        S_REFILL = 2'd3
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 4;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    function automatic int tag_w(input int index_w);
        return 28 - index_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_store.sv
// ============================================================================
// Module   : icache_line_store
// Brief    : Direct-mapped valid/tag/data arrays, async read, one sync write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_store #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [127:0]       rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [127:0]       wr_line
);

    localparam int c_depth = 2 ** INDEX_W;

    logic [c_depth-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_depth];
    logic [127:0]       r_line [c_depth];

    // Only the valid bits are cleared; tag and data are qualified by them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_line[wr_index] <= wr_line;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_line  = r_line[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache_fetch_responder.sv
// ============================================================================
// Module   : icache_fetch_responder
// Brief    : Fetch-request responder with direct-mapped I-cache and burst refill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fetch_responder
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         valid,
    input  logic [31:0]  iaddr,
    input  logic         uncached,
    input  logic         flush,
    output logic         addr_ok,
    output logic         data_ok,
    output logic [127:0] rdata,
    output logic         rd_req,
    output logic [31:0]  rd_addr,
    output logic         rd_uncached,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data
);

    localparam int c_tag_w  = tag_w(INDEX_W);
    localparam int c_line_w = 32 - OFFSET_W;

    state_t r_state, w_next_state;

    logic [c_line_w-1:0]             r_req_line;
    logic                            r_req_uncached;
    logic [LINE_WORDS-1:0][31:0]     r_fill_buf;
    logic [LINE_WORDS-1:0][31:0]     w_fill_line;
    logic [1:0]                      r_beat_cnt;
    logic                            r_cancel;
    logic                            r_refill_done;
    logic [127:0]                    r_rdata;

    logic [INDEX_W-1:0] w_req_index;
    logic [c_tag_w-1:0] w_req_tag;
    logic               w_lu_valid;
    logic [c_tag_w-1:0] w_lu_tag;
    logic [127:0]       w_lu_line;
    logic               w_hit;
    logic               w_hit_ok;
    logic               w_addr_ok;
    logic               w_data_ok;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_arr_we;
    logic               w_unused_ok;

    assign w_req_index = r_req_line[INDEX_W-1:0];
    assign w_req_tag   = r_req_line[c_line_w-1:INDEX_W];

    icache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (c_tag_w)
    ) u_line_store (
        .clk      (clk),
        .resetn   (resetn),
        .rd_index (w_req_index),
        .rd_valid (w_lu_valid),
        .rd_tag   (w_lu_tag),
        .rd_line  (w_lu_line),
        .wr_en    (w_arr_we),
        .wr_index (w_req_index),
        .wr_tag   (w_req_tag),
        .wr_line  (w_fill_line)
    );

    assign w_hit    = (r_state == S_LOOKUP) && w_lu_valid && (w_lu_tag == w_req_tag)
                      && !r_req_uncached;
    assign w_hit_ok = w_hit && !flush;

    always_comb begin
        w_next_state = r_state;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;
        rd_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_ok = 1'b1;
                w_data_ok = r_refill_done;
                if (valid) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (flush || w_hit) begin
                    w_addr_ok    = 1'b1;
                    w_data_ok    = !flush;
                    w_next_state = valid ? S_LOOKUP : S_IDLE;
                end else begin
                    w_next_state = S_MISS;
                end
            end
            S_MISS: begin
                rd_req = 1'b1;
                // A grant in the flush cycle commits the burst; it must be drained.
                if (rd_rdy)     w_next_state = S_REFILL;
                else if (flush) w_next_state = S_IDLE;
            end
            S_REFILL: begin
                if (ret_valid && ret_last) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign addr_ok     = w_addr_ok && resetn;
    assign data_ok     = w_data_ok;
    assign w_accept    = valid && addr_ok;
    assign rdata       = w_hit_ok ? w_lu_line : r_rdata;
    assign rd_addr     = (r_state == S_MISS) ? {r_req_line, {OFFSET_W{1'b0}}} : 32'd0;
    assign rd_uncached = (r_state == S_MISS) && r_req_uncached;

    assign w_last_beat = (r_state == S_REFILL) && ret_valid && ret_last;
    assign w_arr_we    = w_last_beat && !r_req_uncached;

    // Final beat goes straight into the line so the array write needs no extra cycle.
    always_comb begin
        w_fill_line             = r_fill_buf;
        w_fill_line[r_beat_cnt] = ret_data;
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && ret_valid) begin
            r_fill_buf[r_beat_cnt] <= ret_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_req_line     <= '0;
            r_req_uncached <= 1'b0;
            r_beat_cnt     <= 2'd0;
            r_cancel       <= 1'b0;
            r_refill_done  <= 1'b0;
            r_rdata        <= '0;
        end else begin
            r_state       <= w_next_state;
            r_refill_done <= 1'b0;
            if (w_accept) begin
                r_req_line     <= iaddr[31:OFFSET_W];
                r_req_uncached <= uncached;
            end
            if (w_hit_ok) begin
                r_rdata <= w_lu_line;
            end
            if ((r_state == S_MISS) && rd_rdy) begin
                r_beat_cnt <= 2'd0;
                r_cancel   <= flush;
            end
            if (r_state == S_REFILL) begin
                if (ret_valid) r_beat_cnt <= r_beat_cnt + 2'd1;
                if (flush)     r_cancel   <= 1'b1;
                if (w_last_beat) begin
                    r_cancel      <= 1'b0;
                    r_refill_done <= !(r_cancel || flush);
                    if (!(r_cancel || flush)) r_rdata <= w_fill_line;
                end
            end
        end
    end

    assign w_unused_ok = &{1'b0, iaddr[OFFSET_W-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch_responder.sv
// ============================================================================
// Module   : tb_icache_fetch_responder
// Brief    : Directed self-checking bench for the fetch responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_fetch_responder;
    import icache_pkg::*;

    logic         clk;
    logic         resetn;
    logic         valid;
    logic [31:0]  iaddr;
    logic         uncached;
    logic         flush;
    logic         addr_ok;
    logic         data_ok;
    logic [127:0] rdata;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_uncached;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] c_line_a = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] c_line_u = {32'hdd, 32'hcc, 32'hbb, 32'haa};
    localparam logic [127:0] c_line_c = {32'h88, 32'h77, 32'h66, 32'h55};
    localparam logic [127:0] c_line_f = {32'hf4, 32'hf3, 32'hf2, 32'hf1};

    icache_fetch_responder #(.INDEX_W(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .iaddr       (iaddr),
        .uncached    (uncached),
        .flush       (flush),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .rdata       (rdata),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_uncached (rd_uncached),
        .rd_rdy      (rd_rdy),
        .ret_valid   (ret_valid),
        .ret_last    (ret_last),
        .ret_data    (ret_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic unc, input logic [127:0] line);
        step(); valid = 1'b1; iaddr = addr; uncached = unc; #1;
        check("miss_accept", 128'(addr_ok), 128'h1);
        step(); valid = 1'b0; uncached = 1'b0; #1;
        check("miss_lookup_no_data", 128'(data_ok), 128'h0);
        check("miss_lookup_no_req", 128'(rd_req), 128'h0);
        step(); rd_rdy = 1'b1; #1;
        check("miss_rd_req", 128'(rd_req), 128'h1);
        check("miss_rd_addr", 128'(rd_addr), 128'({addr[31:4], 4'h0}));
        check("miss_rd_uncached", 128'(rd_uncached), 128'(unc));
        for (int i = 0; i < 4; i++) begin
            step(); rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = line[32*i +: 32];
            ret_last = (i == 3); #1;
            check("refill_no_data", 128'(data_ok), 128'h0);
        end
        step(); ret_valid = 1'b0; ret_last = 1'b0; #1;
        check("refill_data_ok", 128'(data_ok), 128'h1);
        check("refill_rdata", rdata, line);
        step(); #1;
        check("refill_single_pulse", 128'(data_ok), 128'h0);
        check("refill_rdata_hold", rdata, line);
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [127:0] line);
        step(); valid = 1'b1; iaddr = addr; #1;
        check("hit_accept", 128'(addr_ok), 128'h1);
        step(); valid = 1'b0; #1;
        check("hit_data_ok", 128'(data_ok), 128'h1);
        check("hit_rdata", rdata, line);
        check("hit_no_req", 128'(rd_req), 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; valid = 1'b0; iaddr = 32'd0; uncached = 1'b0; flush = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
        repeat (2) step();
        #1;
        check("rst_addr_ok", 128'(addr_ok), 128'h0);
        check("rst_data_ok", 128'(data_ok), 128'h0);
        check("rst_rd_req", 128'(rd_req), 128'h0);
        check("rst_rd_addr", 128'(rd_addr), 128'h0);
        check("rst_rdata", rdata, 128'h0);
        step(); resetn = 1'b1;

        // Cold miss and fill
        fetch_miss(RESET_PC, 1'b0, c_line_a);

        // Back-to-back hits on the same line
        step(); valid = 1'b1; iaddr = RESET_PC + 32'h8; #1;
        check("b2b_accept0", 128'(addr_ok), 128'h1);
        step(); iaddr = RESET_PC; #1;
        check("b2b_data_ok0", 128'(data_ok), 128'h1);
        check("b2b_rdata0", rdata, c_line_a);
        check("b2b_accept1", 128'(addr_ok), 128'h1);
        step(); valid = 1'b0; #1;
        check("b2b_data_ok1", 128'(data_ok), 128'h1);
        check("b2b_rdata1", rdata, c_line_a);
        check("b2b_no_req", 128'(rd_req), 128'h0);
        step(); #1;
        check("b2b_idle_no_data", 128'(data_ok), 128'h0);

        // Uncached read bypasses allocation
        fetch_miss(RESET_PC, 1'b1, c_line_u);
        fetch_hit(RESET_PC, c_line_a);

        // Conflict on the same index evicts the earlier line
        fetch_miss(RESET_PC + 32'h400, 1'b0, c_line_c);
        fetch_miss(RESET_PC, 1'b0, c_line_a);

        // Flush during the refill: no response, but the line is allocated
        step(); valid = 1'b1; iaddr = RESET_PC + 32'h10; #1;
        check("fr_accept", 128'(addr_ok), 128'h1);
        step(); valid = 1'b0; #1;
        step(); rd_rdy = 1'b1; #1;
        check("fr_rd_req", 128'(rd_req), 128'h1);
        for (int i = 0; i < 4; i++) begin
            step(); rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = c_line_f[32*i +: 32];
            ret_last = (i == 3); flush = (i == 1); #1;
            check("fr_refill_addr_ok", 128'(addr_ok), 128'h0);
        end
        step(); ret_valid = 1'b0; ret_last = 1'b0; flush = 1'b0; #1;
        check("fr_no_data_ok", 128'(data_ok), 128'h0);
        check("fr_rdata_held", rdata, c_line_a);
        step(); #1;
        check("fr_no_late_data_ok", 128'(data_ok), 128'h0);
        fetch_hit(RESET_PC + 32'h10, c_line_f);

        // Flush in MISS before grant
        step(); valid = 1'b1; iaddr = RESET_PC + 32'h20; #1;
        step(); valid = 1'b0; #1;
        step(); flush = 1'b1; #1;
        check("fm_rd_req_flush_cycle", 128'(rd_req), 128'h1);
        step(); flush = 1'b0; #1;
        check("fm_rd_req_dropped", 128'(rd_req), 128'h0);
        check("fm_no_data_ok", 128'(data_ok), 128'h0);
        check("fm_addr_ok_idle", 128'(addr_ok), 128'h1);

        // Request accepted in the LOOKUP flush cycle is live
        step(); valid = 1'b1; iaddr = RESET_PC + 32'h20; #1;
        step(); flush = 1'b1; iaddr = RESET_PC + 32'h4; #1;
        check("fl_addr_ok", 128'(addr_ok), 128'h1);
        check("fl_no_data_ok", 128'(data_ok), 128'h0);
        step(); flush = 1'b0; valid = 1'b0; #1;
        check("fl_new_data_ok", 128'(data_ok), 128'h1);
        check("fl_new_rdata", rdata, c_line_a);
        step(); #1;
        check("fl_no_req", 128'(rd_req), 128'h0);
        check("fl_idle_no_data", 128'(data_ok), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_fetch_responder.md
# icache_fetch_responder

Responder end of the instruction-fetch request interface: accepts one fetch request per handshake from the fetch-address stage (`valid`/`iaddr`/`uncached` → `addr_ok`) and returns the full 16-byte line (four instructions) with `data_ok`. It holds a direct-mapped, flop-based instruction cache and refills misses through a burst read port toward the bus bridge. It sits between IF stage 0/IF stage 1 and the AXI read arbiter.

## Interface
- `INDEX_W`, 6: set-index width; 2^INDEX_W lines of 16 B. Tag = `iaddr[31:4+INDEX_W]`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `valid` in 1: fetch request.
- `iaddr` in 32: fetch address. Bits [3:0] are ignored for lookup.
- `uncached` in 1: bypass the array. The line is read but not allocated.
- `flush` in 1: cancels the in-flight request (redirect).
- `addr_ok` out 1: request accepted this cycle when `valid & addr_ok`.
- `data_ok` out 1: one-cycle pulse marking `rdata` valid.
- `rdata` out 128: line data; word i = `rdata[32i+31:32i]` = address `{line,i,2'b00}`.
- `rd_req` out 1: refill request; held until `rd_rdy`.
- `rd_addr` out 32: line-aligned address (`[3:0]=0`).
- `rd_uncached` out 1: bus attribute of the refill.
- `rd_rdy` in 1: refill request accepted.
- `ret_valid` in 1: return beat valid.
- `ret_last` in 1: final (4th) beat.
- `ret_data` in 32: return beat data, ascending word order.

## Operation
States: IDLE, LOOKUP, MISS, REFILL.
- `addr_ok` is asserted in IDLE, and in LOOKUP when the lookup hits or is flushed. It is 0 in MISS/REFILL and while `resetn`=0.
- **Acceptance:** the address, uncached flag and index/tag are captured into a request register, and the next state is LOOKUP.
- **IDLE:** on acceptance → LOOKUP, otherwise stay.
- **LOOKUP:** compare the stored tag against the array entry (valid & tag match & !uncached).
  - Hit: `data_ok`=1, `rdata`=array line. Next state is LOOKUP if a new request is accepted this cycle, else IDLE.
  - Miss or uncached → MISS.
- **MISS:** `rd_req`=1, `rd_addr`={tag,index,4'b0}, `rd_uncached`=stored flag. On `rd_rdy` → REFILL with beat counter = 0.
- **REFILL:** each `ret_valid` writes `ret_data` into refill buffer word [counter] and increments the 2-bit counter.
  - On `ret_valid & ret_last`: if cached, write tag, valid and the full line (including the final beat) into the array; → IDLE.
  - In the following cycle (IDLE), `data_ok`=1 and `rdata`=refill buffer, unless the request was cancelled.
- **flush:**
  - LOOKUP: suppress `data_ok`; → IDLE, or LOOKUP if a request is accepted this cycle.
  - MISS before `rd_rdy`: drop `rd_req`; → IDLE.
  - MISS with `rd_rdy` in the same cycle: the bus transaction is committed; treat as REFILL with cancel.
  - REFILL: set the cancel flag, keep draining beats, still allocate if cached, suppress the final `data_ok`. The cancel flag clears when entering IDLE.
  - A request accepted in the same cycle as `flush` is live and is not cancelled.
- `ret_valid` outside REFILL is ignored.

## Timing
- Reset (async, `resetn`=0): state=IDLE, all line valid bits=0, `data_ok`=0, `rd_req`=0, `rdata`=0, `rd_addr`=0, beat counter=0, cancel=0. The tag/data arrays are not reset.
- Hit latency: accept at cycle T → `data_ok` at T+1.
- Back-to-back hits sustain one line per cycle.
- Miss: accept at T, `rd_req` from T+2. The `data_ok` cycle is the cycle after `ret_last`.
- `data_ok` never asserts twice for one request and never for a cancelled one.
- `rdata` holds its value until the next `data_ok`.
- An array write at `ret_last` is visible to a lookup one cycle later. No bypass is needed because `addr_ok`=0 during REFILL.

## Structure
- Package `icache_pkg`:
  - State enum.
  - `LINE_WORDS=4`, `OFFSET_W=4`.
  - `tag_w(INDEX_W)` = 28-INDEX_W.
  - Reset PC constant `32'h1c000000` for bench use.
- One sub-module `icache_line_store`: valid/tag/data arrays, async read by index, one synchronous write port (index, tag, 128-bit line), and async valid clear on `resetn`.
- The FSM, request register, refill buffer, beat counter and cancel flag live in the top module.

## Test plan
- Reset, then request `0x1c000000` cached.
  - Required: `addr_ok`=1 at accept, `rd_req` two cycles later with `rd_addr`=`0x1c000000`.
  - Beats `0x11,0x22,0x33,0x44` → `data_ok` with `rdata`=`{0x44,0x33,0x22,0x11}`.
- Re-request `0x1c000008` then `0x1c000000` back-to-back. Required: both hit, `data_ok` on consecutive cycles with the same line, and no `rd_req`.
- Uncached request to `0x1c000000` (already cached). Required: `rd_req` with `rd_uncached`=1. After the refill, a cached request for the same address still hits the old data.
- Conflict: fill `0x1c000000`, then request `0x1c000400` (same index for `INDEX_W`=6). Required: miss and refill, after which `0x1c000000` misses again.
- `flush` during REFILL beat 2 of `0x1c000010`. Required: no `data_ok`, the line is still allocated, and a later request for `0x1c000010` hits.
- `flush` in MISS before `rd_rdy`. Required: `rd_req` drops the next cycle. A request accepted in the flush cycle in LOOKUP returns `data_ok`.
